// File: rtl/iic_bus_pkg.sv
// Shared types and constants for the 68k-to-I2C-core bus bridge.
package iic_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DTACK = 2'd2,
    ST_BERR  = 2'd3
  } iic_state_e;

  localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

  // Core register offsets (WB_Adr_o values)
  localparam logic [2:0] IIC_REG_PRER_LO = 3'd0;
  localparam logic [2:0] IIC_REG_PRER_HI = 3'd1;
  localparam logic [2:0] IIC_REG_CTR     = 3'd2;
  localparam logic [2:0] IIC_REG_TXR_RXR = 3'd3;
  localparam logic [2:0] IIC_REG_CR_SR   = 3'd4;

endpackage

// File: rtl/iic_bus_timer.sv
// Core-response watchdog: counts REQ cycles without ack; expired marks the
// edge on which the count reaches TIMEOUT_CYCLES.
module iic_bus_timer
  import iic_bus_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == (TIMEOUT_CYCLES - 8'd1));

endmodule

// File: rtl/iic_bus_controller.sv
// Bridges a 68k bus cycle onto one Wishbone access of the I2C core and
// terminates the 68k cycle with DTACK, or BERR if the core never answers.
module iic_bus_controller
  import iic_bus_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_H,
  input  logic        IIC0_Enable_H,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic [2:0]  Address,
  input  logic [15:0] DataIn,
  input  logic        WB_Ack_i,
  input  logic [7:0]  WB_Dat_i,
  output logic        WB_Cyc_o,
  output logic        WB_Stb_o,
  output logic        WB_We_o,
  output logic [2:0]  WB_Adr_o,
  output logic [7:0]  WB_Dat_o,
  output logic [15:0] DataOut,
  output logic        IIC_DtAck_L,
  output logic        IIC_BErr_L,
  output logic        Busy_H
);

  iic_state_e  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [15:0] dout_q, dout_d;
  logic        dtack_l_q, dtack_l_d;
  logic        berr_l_q, berr_l_d;
  logic        armed_q, armed_d;
  logic        start;
  logic        timer_en;
  logic        timer_expired;

  // armed_q blocks a second access within the same AS_L-low window, including
  // the window still open when a reset lands mid-cycle.
  assign start    = (state_q == ST_IDLE) && armed_q && IIC0_Enable_H && !AS_L
                    && (!UDS_L || !LDS_L);
  assign timer_en = (state_q == ST_REQ) && !WB_Ack_i;

  iic_bus_timer u_timer (
    .clk     (Clk),
    .srst    (Reset_H),
    .clear   (start),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    dout_d    = dout_q;
    dtack_l_d = dtack_l_q;
    berr_l_d  = berr_l_q;
    armed_d   = armed_q | AS_L;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          cyc_d   = 1'b1;
          we_d    = ~WE_L;
          adr_d   = Address;
          dat_d   = LDS_L ? DataIn[15:8] : DataIn[7:0];
          armed_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (WB_Ack_i) begin
          cyc_d = 1'b0;
          if (!we_q) begin
            dout_d = {WB_Dat_i, WB_Dat_i};
          end
          if (!AS_L) begin
            state_d   = ST_DTACK;
            dtack_l_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timer_expired) begin
          cyc_d    = 1'b0;
          state_d  = ST_BERR;
          berr_l_d = 1'b0;
        end
      end
      ST_DTACK, ST_BERR: begin
        if (AS_L) begin
          state_d   = ST_IDLE;
          dtack_l_d = 1'b1;
          berr_l_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      dat_q     <= 8'd0;
      dout_q    <= 16'd0;
      dtack_l_q <= 1'b1;
      berr_l_q  <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      dout_q    <= dout_d;
      dtack_l_q <= dtack_l_d;
      berr_l_q  <= berr_l_d;
      armed_q   <= armed_d;
    end
  end

  assign WB_Cyc_o    = cyc_q;
  assign WB_Stb_o    = cyc_q;
  assign WB_We_o     = we_q;
  assign WB_Adr_o    = adr_q;
  assign WB_Dat_o    = dat_q;
  assign DataOut     = dout_q;
  assign IIC_DtAck_L = dtack_l_q;
  assign IIC_BErr_L  = berr_l_q;
  assign Busy_H      = (state_q != ST_IDLE);

endmodule

// File: doc/iic_bus_controller.md
IIC_BUS_CONTROLLER -- requirements
Module: iic_bus_controller

Interface
REQ-001 SHALL have port Clk, input, 1, single clock for all logic.
REQ-002 SHALL have port Reset_H, input, 1, synchronous active-high reset.
REQ-003 SHALL have port IIC0_Enable_H, input, 1, decoder select: CPU access in 0x00408000-0x0040800F with AS_L low.
REQ-004 SHALL have port AS_L, input, 1, 68k address strobe.
REQ-005 SHALL have port WE_L, input, 1, 68k write strobe (0 = write, 1 = read).
REQ-006 SHALL have ports UDS_L and LDS_L, input, 1 each, 68k data strobes.
REQ-007 SHALL have port Address, input, 3 (bits 3:1), selects the core register.
REQ-008 SHALL have port DataIn, input, 16, CPU write data.
REQ-009 SHALL have ports WB_Ack_i (input, 1) and WB_Dat_i (input, 8), the I2C core acknowledge and read data.
REQ-010 SHALL have ports WB_Cyc_o, WB_Stb_o and WB_We_o, output, 1 each; WB_Adr_o, output, 3; and WB_Dat_o, output, 8 (I2C core bus).
REQ-011 SHALL have port DataOut, output, 16, read data to the CPU.
REQ-012 SHALL have ports IIC_DtAck_L and IIC_BErr_L, output, 1 each, 68k termination.
REQ-013 SHALL have port Busy_H, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement four states: IDLE, REQ, DTACK, BERR.
REQ-015 IDLE->REQ SHALL occur on the edge where IIC0_Enable_H=1 and (UDS_L=0 or LDS_L=0).
- On that edge: capture Address -> WB_Adr_o and ~WE_L -> WB_We_o.
- Capture WB_Dat_o as DataIn[7:0] if LDS_L=0, else DataIn[15:8].
REQ-016 In REQ, WB_Cyc_o and WB_Stb_o SHALL be 1 (registered).
- They go high the cycle after the IDLE->REQ edge.
- Address, write flag and write data SHALL stay stable for the whole of REQ.
REQ-017 In REQ, on an edge with WB_Ack_i=1:
- Drop Cyc/Stb.
- For reads, latch DataOut = {WB_Dat_i, WB_Dat_i}.
- Go to DTACK if AS_L=0, else go to IDLE (aborted access, no termination driven).
REQ-018 The timeout counter SHALL be 8 bits wide, cleared on entry to REQ and incremented on each REQ cycle without ack.
- When it reaches TIMEOUT_CYCLES (255) and ack is absent: drop Cyc/Stb and go to BERR.
- Ack on the timeout edge wins and follows REQ-017.
REQ-019 In DTACK, IIC_DtAck_L SHALL be 0; in BERR, IIC_BErr_L SHALL be 0.
- Both states SHALL return to IDLE on the first edge with AS_L=1.
- Termination deasserts on that same edge.
REQ-020 Latency: enable at edge N -> Stb high after N. Ack at edge M -> DtAck_L low after M. Stb and DtAck_L SHALL never be active in the same cycle.
REQ-021 WB_Ack_i SHALL be ignored in IDLE, DTACK and BERR.
REQ-022 A new access SHALL NOT start until AS_L has returned high, so each 68k cycle produces exactly one core transaction.
REQ-023 DataOut SHALL hold its last read value until the next read ack; write cycles SHALL NOT alter DataOut.

Reset
REQ-024 On any edge with Reset_H=1, from any state including mid-REQ:
- state = IDLE;
- WB_Cyc_o = WB_Stb_o = WB_We_o = 0;
- WB_Adr_o = 0, WB_Dat_o = 0, DataOut = 0;
- IIC_DtAck_L = IIC_BErr_L = 1, Busy_H = 0;
- timeout counter = 0.

Structure
REQ-025 The state enum, TIMEOUT_CYCLES and the core register offsets SHALL live in shared package iic_bus_pkg.
REQ-026 The timeout counter SHALL be a sub-module, iic_bus_timer, with clear, enable and expired signals.

Verification
REQ-027 Bench SHALL cover the following directed scenarios:
- Write: Address=3'b010, LDS_L=0, DataIn=16'h00A5, WE_L=0 -> one Stb cycle with Adr=2, We=1, Dat=A5; ack after 3 cycles -> DtAck_L low until AS_L high.
- Read: Address=3'b100, UDS_L=0, WE_L=1, core returns 8'h3C -> DataOut=16'h3C3C while DtAck_L=0; exactly one Stb assertion.
- Timeout: no ack -> Cyc/Stb drop after 255 REQ cycles -> BErr_L=0 until AS_L high; DtAck_L stays 1.
- Abort: AS_L rises mid-REQ, ack arrives later -> return to IDLE; neither DtAck_L nor BErr_L asserted.
- Reset: Reset_H pulse during REQ -> next cycle all outputs at reset values and no further Stb.
- Back-to-back: two accesses separated by one AS_L-high cycle -> two distinct core transactions, no merging or duplication.
